// File: rtl/display_frame_buffer_pkg.sv
// Shared display definitions: frame geometry, segment bit masks, FSM state
// encoding and the byte-write request payload.
package display_frame_buffer_pkg;

    localparam int unsigned FRAME_BYTES = 9;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned FRAME_W     = FRAME_BYTES * BYTE_W;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned SEG_W       = 7;

    // Active-high segment masks, a = bit0 .. g = bit6; DP lives in bit 7 of a byte.
    localparam logic [SEG_W-1:0] SEG_A = 7'h01;
    localparam logic [SEG_W-1:0] SEG_B = 7'h02;
    localparam logic [SEG_W-1:0] SEG_C = 7'h04;
    localparam logic [SEG_W-1:0] SEG_D = 7'h08;
    localparam logic [SEG_W-1:0] SEG_E = 7'h10;
    localparam logic [SEG_W-1:0] SEG_F = 7'h20;
    localparam logic [SEG_W-1:0] SEG_G = 7'h40;
    localparam int unsigned      SEG_DP_BIT = 7;

    // Publish FSM states.
    typedef logic [0:0] fsm_state_t;
    localparam fsm_state_t IDLE    = 1'b0;
    localparam fsm_state_t PENDING = 1'b1;

    // One byte-write request as presented on the write port.
    typedef struct packed {
        logic              hex;
        logic [ADDR_W-1:0] addr;
        logic [BYTE_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/display_frame_buffer_seg7_encode.sv
// Hex nibble to active-high 7-segment glyph (a = bit0 .. g = bit6).
// Ports: nibble - 4-bit hex value; seg_c - combinational segment pattern.
module seg7_encode
    import display_frame_buffer_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = '0;
        case (nibble)
            4'h0: seg_c = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
            4'h1: seg_c = SEG_B | SEG_C;
            4'h2: seg_c = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
            4'h3: seg_c = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
            4'h4: seg_c = SEG_B | SEG_C | SEG_F | SEG_G;
            4'h5: seg_c = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
            4'h6: seg_c = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'h7: seg_c = SEG_A | SEG_B | SEG_C;
            4'h8: seg_c = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'h9: seg_c = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
            4'hA: seg_c = SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G;
            4'hB: seg_c = SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'hC: seg_c = SEG_A | SEG_D | SEG_E | SEG_F;
            4'hD: seg_c = SEG_B | SEG_C | SEG_D | SEG_E | SEG_G;
            4'hE: seg_c = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G;
            4'hF: seg_c = SEG_A | SEG_E | SEG_F | SEG_G;
            default: seg_c = '0;
        endcase
    end

endmodule

// File: rtl/display_frame_buffer.sv
// Nine-byte display frame buffer: byte writes land in a shadow buffer, and a
// commit, blank change or refresh expiry publishes the shadow to display_bits
// with a req/ack handshake towards the shift-out driver.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   wr_valid/ready   - byte write handshake (ready is always high after reset)
//   wr_addr/data/hex - byte index 0..8, raw byte or nibble+DP, hex-encode select
//   commit           - publish request pulse
//   blank            - level: publish all-zero frame; any change also publishes
//   frame_req/ack    - new-frame flag to the shifter and its load pulse back
//   display_bits     - published frame, held while frame_req is high
//   addr_err         - sticky out-of-range write flag
module display_frame_buffer
    import display_frame_buffer_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 1000000,
    parameter bit          HEX_EN         = 1'b1
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [BYTE_W-1:0]  wr_data,
    input  logic               wr_hex,
    input  logic               commit,
    input  logic               blank,
    output logic               frame_req,
    input  logic               frame_ack,
    output logic [FRAME_W-1:0] display_bits,
    output logic               addr_err
);

    localparam bit          REFRESH_EN   = (REFRESH_CYCLES != 0);
    localparam int unsigned REFRESH_LAST = REFRESH_EN ? REFRESH_CYCLES - 1 : 0;
    localparam int unsigned CNT_W        = (REFRESH_LAST < 1) ? 1 : $clog2(REFRESH_LAST + 1);

    fsm_state_t         state_q, state_nxt;
    logic [FRAME_W-1:0] shadow_q, shadow_nxt;
    logic [FRAME_W-1:0] display_q, display_nxt;
    logic               frame_req_q, frame_req_nxt;
    logic               pend_q, pend_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic               addr_err_q;
    logic               blank_q;
    logic               wr_ready_q;

    wr_req_t            wr_req_c;
    logic [SEG_W-1:0]   glyph_c;
    logic [BYTE_W-1:0]  wr_byte_c;
    logic               wr_fire_c;
    logic               addr_ok_c;
    logic               commit_ev_c;
    logic               refresh_ev_c;

    assign wr_req_c = '{hex: wr_hex, addr: wr_addr, data: wr_data};

    seg7_encode u_seg7_encode (
        .nibble (wr_req_c.data[3:0]),
        .seg_c  (glyph_c)
    );

    // Byte that a write stores: hex glyph with DP from data[7], or the raw byte.
    always_comb begin
        wr_byte_c = wr_req_c.data;
        if (HEX_EN && wr_req_c.hex) begin
            wr_byte_c                        = {1'b0, glyph_c};
            wr_byte_c[SEG_DP_BIT]            = wr_req_c.data[SEG_DP_BIT];
        end
    end

    assign wr_fire_c = wr_valid & wr_ready_q;
    assign addr_ok_c = (wr_req_c.addr < ADDR_W'(FRAME_BYTES));

    // Shadow with this cycle's write applied, so a coincident commit publishes it.
    always_comb begin
        shadow_nxt = shadow_q;
        if (wr_fire_c && addr_ok_c) begin
            for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
                if (wr_req_c.addr == ADDR_W'(i)) begin
                    shadow_nxt[BYTE_W*i +: BYTE_W] = wr_byte_c;
                end
            end
        end
    end

    // A blank toggle is treated exactly like a commit.
    assign commit_ev_c  = commit | (blank ^ blank_q);
    assign refresh_ev_c = REFRESH_EN && (state_q == IDLE) && (cnt_q == CNT_W'(REFRESH_LAST));

    // Publish FSM next-state and output logic.
    always_comb begin
        state_nxt     = state_q;
        frame_req_nxt = frame_req_q;
        display_nxt   = display_q;
        pend_nxt      = pend_q;
        cnt_nxt       = cnt_q;
        case (state_q)
            IDLE: begin
                // Commit, refresh and a deferred commit all collapse into one publish.
                if (commit_ev_c || refresh_ev_c || pend_q) begin
                    state_nxt     = PENDING;
                    frame_req_nxt = 1'b1;
                    display_nxt   = blank ? '0 : shadow_nxt;
                    pend_nxt      = 1'b0;
                    cnt_nxt       = '0;
                end else if (REFRESH_EN) begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            PENDING: begin
                if (commit_ev_c) begin
                    pend_nxt = 1'b1;
                end
                if (frame_ack) begin
                    state_nxt     = IDLE;
                    frame_req_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt     = IDLE;
                frame_req_nxt = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            display_q   <= '0;
            frame_req_q <= 1'b0;
            pend_q      <= 1'b0;
            cnt_q       <= '0;
            addr_err_q  <= 1'b0;
            blank_q     <= 1'b0;
            wr_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            shadow_q    <= shadow_nxt;
            display_q   <= display_nxt;
            frame_req_q <= frame_req_nxt;
            pend_q      <= pend_nxt;
            cnt_q       <= cnt_nxt;
            addr_err_q  <= addr_err_q | (wr_fire_c & ~addr_ok_c);
            blank_q     <= blank;
            wr_ready_q  <= 1'b1;
        end
    end

    assign wr_ready     = wr_ready_q;
    assign frame_req    = frame_req_q;
    assign display_bits = display_q;
    assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_display_frame_buffer.sv
// Directed bench for display_frame_buffer: main instance with refresh disabled,
// second instance with a 16-cycle refresh whose ack follows frame_req.
module tb_display_frame_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_hex;
    logic        commit;
    logic        blank;
    logic        frame_req;
    logic        frame_ack;
    logic [71:0] display_bits;
    logic        addr_err;

    logic        rf_wr_ready;
    logic        rf_frame_req;
    logic        rf_frame_ack;
    logic [71:0] rf_display_bits;
    logic        rf_addr_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rise_q[$];
    logic rf_req_d = 1'b0;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Shadow contents after the hex/write-through steps, then after the merge step.
    localparam logic [71:0] D0 = {8'h3C, 32'h0, 8'h71, 8'h5A, 8'h00, 8'hA5};
    localparam logic [71:0] D1 = {8'h3C, 32'h0, 8'h71, 8'h5A, 8'h11, 8'hA5};

    always #5 clk = ~clk;

    display_frame_buffer #(.REFRESH_CYCLES(0), .HEX_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_hex(wr_hex), .commit(commit),
        .blank(blank), .frame_req(frame_req), .frame_ack(frame_ack),
        .display_bits(display_bits), .addr_err(addr_err)
    );

    display_frame_buffer #(.REFRESH_CYCLES(16), .HEX_EN(1'b1)) dut_rf (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rf_wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_hex(wr_hex), .commit(commit),
        .blank(blank), .frame_req(rf_frame_req), .frame_ack(rf_frame_ack),
        .display_bits(rf_display_bits), .addr_err(rf_addr_err)
    );

    // Shifter model for the refresh instance: acks as soon as a frame is offered.
    assign rf_frame_ack = rf_frame_req;

    always @(posedge clk) cyc = cyc + 1;

    // Record the cycle of every frame_req rising edge of the refresh instance.
    always @(negedge clk) begin
        if (rf_frame_req && !rf_req_d) rise_q.push_back(cyc);
        rf_req_d = rf_frame_req;
    end

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic h);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_hex = h;
        @(negedge clk);
        wr_valid = 1'b0; wr_hex = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic send_ack();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_hex = 1'b0;
        commit = 1'b0; blank = 1'b0; frame_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (frame_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", frame_req); end
        checks++;
        if (display_bits !== 72'h0) begin failures++; $display("FAIL reset_display: got %h expected 0", display_bits); end
        checks++;
        if (addr_err !== 1'b0) begin failures++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin failures++; $display("FAIL wr_ready: got %b expected 1", wr_ready); end
        checks++;
        if (frame_req !== 1'b0) begin failures++; $display("FAIL no_publish_after_reset: got %b expected 0", frame_req); end
    endtask

    task automatic test_raw_write();
        do_write(4'd0, 8'hA5, 1'b0);
        do_write(4'd8, 8'h3C, 1'b0);
        pulse_commit();
        checks++;
        if (frame_req !== 1'b1) begin failures++; $display("FAIL raw_req: got %b expected 1", frame_req); end
        checks++;
        if (display_bits[7:0] !== 8'hA5) begin failures++; $display("FAIL raw_byte0: got %h expected a5", display_bits[7:0]); end
        checks++;
        if (display_bits[71:64] !== 8'h3C) begin failures++; $display("FAIL raw_byte8: got %h expected 3c", display_bits[71:64]); end
        checks++;
        if (display_bits !== {8'h3C, 56'h0, 8'hA5}) begin failures++; $display("FAIL raw_frame: got %h expected %h", display_bits, {8'h3C, 56'h0, 8'hA5}); end
        repeat (3) @(negedge clk);
        checks++;
        if (frame_req !== 1'b1) begin failures++; $display("FAIL raw_req_hold: got %b expected 1", frame_req); end
        send_ack();
        checks++;
        if (frame_req !== 1'b0) begin failures++; $display("FAIL raw_req_drop: got %b expected 0", frame_req); end
    endtask

    task automatic test_hex();
        for (int i = 0; i < 16; i++) begin
            do_write(4'd3, {1'b1, 3'b000, 4'(i)}, 1'b1);
            pulse_commit();
            checks++;
            if (frame_req !== 1'b1) begin failures++; $display("FAIL hex_req[%0d]: got %b expected 1", i, frame_req); end
            checks++;
            if ({display_bits[31:24], display_bits[7:0]} !== {1'b1, glyph_tab[i], 8'hA5}) begin
                failures++;
                $display("FAIL hex_glyph[%0d]: got %h expected %h", i,
                         {display_bits[31:24], display_bits[7:0]}, {1'b1, glyph_tab[i], 8'hA5});
            end
            send_ack();
        end
        do_write(4'd3, 8'h08, 1'b1);
        pulse_commit();
        checks++;
        if (display_bits[31:24] !== 8'h7F) begin failures++; $display("FAIL hex_no_dp: got %h expected 7f", display_bits[31:24]); end
        send_ack();
        // Bits 6:4 are not part of the nibble and must not affect the glyph.
        do_write(4'd3, 8'h7F, 1'b1);
        pulse_commit();
        checks++;
        if (display_bits[31:24] !== 8'h71) begin failures++; $display("FAIL hex_upper_ignored: got %h expected 71", display_bits[31:24]); end
        send_ack();
    endtask

    task automatic test_write_through();
        wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 8'h5A; wr_hex = 1'b0; commit = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0; commit = 1'b0;
        checks++;
        if (frame_req !== 1'b1) begin failures++; $display("FAIL wt_req: got %b expected 1", frame_req); end
        checks++;
        if (display_bits !== D0) begin failures++; $display("FAIL wt_frame: got %h expected %h", display_bits, D0); end
        send_ack();
    endtask

    task automatic test_ack_idle();
        send_ack();
        @(negedge clk);
        checks++;
        if (frame_req !== 1'b0) begin failures++; $display("FAIL ack_idle_req: got %b expected 0", frame_req); end
        checks++;
        if (display_bits !== D0) begin failures++; $display("FAIL ack_idle_frame: got %h expected %h", display_bits, D0); end
    endtask

    task automatic test_pending_merge();
        pulse_commit();
        checks++;
        if (display_bits !== D0 || frame_req !== 1'b1) begin failures++; $display("FAIL merge_first: got %h/%b expected %h/1", display_bits, frame_req, D0); end
        pulse_commit();
        @(negedge clk);
        pulse_commit();
        do_write(4'd1, 8'h11, 1'b0);
        checks++;
        if (display_bits !== D0) begin failures++; $display("FAIL merge_hold: got %h expected %h", display_bits, D0); end
        checks++;
        if (frame_req !== 1'b1) begin failures++; $display("FAIL merge_req_hold: got %b expected 1", frame_req); end
        send_ack();
        checks++;
        if (frame_req !== 1'b0) begin failures++; $display("FAIL merge_req_drop: got %b expected 0", frame_req); end
        @(negedge clk);
        checks++;
        if (frame_req !== 1'b1) begin failures++; $display("FAIL merge_republish_req: got %b expected 1", frame_req); end
        checks++;
        if (display_bits !== D1) begin failures++; $display("FAIL merge_republish_frame: got %h expected %h", display_bits, D1); end
        send_ack();
        repeat (4) @(negedge clk);
        checks++;
        if (frame_req !== 1'b0) begin failures++; $display("FAIL merge_single: got %b expected 0", frame_req); end
    endtask

    task automatic test_addr_err();
        checks++;
        if (addr_err !== 1'b0) begin failures++; $display("FAIL addr_err_pre: got %b expected 0", addr_err); end
        do_write(4'd12, 8'hFF, 1'b0);
        checks++;
        if (addr_err !== 1'b1) begin failures++; $display("FAIL addr_err_set: got %b expected 1", addr_err); end
        pulse_commit();
        checks++;
        if (display_bits !== D1) begin failures++; $display("FAIL addr_err_discard: got %h expected %h", display_bits, D1); end
        send_ack();
        repeat (5) @(negedge clk);
        checks++;
        if (addr_err !== 1'b1) begin failures++; $display("FAIL addr_err_sticky: got %b expected 1", addr_err); end
    endtask

    task automatic test_blank();
        blank = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_req !== 1'b1 || display_bits !== 72'h0) begin failures++; $display("FAIL blank_rise: got %h/%b expected 0/1", display_bits, frame_req); end
        send_ack();
        pulse_commit();
        checks++;
        if (frame_req !== 1'b1 || display_bits !== 72'h0) begin failures++; $display("FAIL blank_commit: got %h/%b expected 0/1", display_bits, frame_req); end
        send_ack();
        blank = 1'b0;
        @(negedge clk);
        checks++;
        if (frame_req !== 1'b1) begin failures++; $display("FAIL unblank_req: got %b expected 1", frame_req); end
        checks++;
        if (display_bits !== D1) begin failures++; $display("FAIL unblank_shadow: got %h expected %h", display_bits, D1); end
        send_ack();
    endtask

    task automatic test_reset_mid_pending();
        pulse_commit();
        checks++;
        if (frame_req !== 1'b1) begin failures++; $display("FAIL rstp_pre: got %b expected 1", frame_req); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (frame_req !== 1'b0) begin failures++; $display("FAIL rstp_req: got %b expected 0", frame_req); end
        checks++;
        if (display_bits !== 72'h0) begin failures++; $display("FAIL rstp_display: got %h expected 0", display_bits); end
        checks++;
        if (addr_err !== 1'b0) begin failures++; $display("FAIL rstp_addr_err: got %b expected 0", addr_err); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (frame_req !== 1'b0) begin failures++; $display("FAIL rstp_no_publish: got %b expected 0", frame_req); end
        pulse_commit();
        checks++;
        if (display_bits !== 72'h0) begin failures++; $display("FAIL rstp_shadow_cleared: got %h expected 0", display_bits); end
        send_ack();
    endtask

    task automatic test_refresh();
        int c0;
        int exp_rise [5] = '{16, 33, 50, 58, 75};
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rise_q.delete();
        rst_n = 1'b1;
        c0 = cyc;
        // Period is 17 edges: 16 IDLE cycles plus the one-cycle PENDING handshake.
        // Commit at edge 50 coincides with a refresh; commit at edge 58 is mid-interval.
        while (cyc < c0 + 80) begin
            @(negedge clk);
            commit = (cyc == c0 + 49) || (cyc == c0 + 57);
        end
        commit = 1'b0;
        checks++;
        if (rise_q.size() !== 5) begin failures++; $display("FAIL refresh_count: got %0d expected 5", rise_q.size()); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k >= rise_q.size()) begin
                failures++; $display("FAIL refresh_rise[%0d]: got none expected %0d", k, exp_rise[k]);
            end else if (rise_q[k] - c0 !== exp_rise[k]) begin
                failures++; $display("FAIL refresh_rise[%0d]: got %0d expected %0d", k, rise_q[k] - c0, exp_rise[k]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_raw_write();
        test_hex();
        test_write_through();
        test_ack_idle();
        test_pending_merge();
        test_addr_err();
        test_blank();
        test_reset_mid_pending();
        test_refresh();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
